// File: rtl/disparity_sequencer.sv
// Frame-level controller that streams the left and then the right camera frame into the disparity engine.
// Optional compute watchdog: define DISP_SEQ_WATCHDOG_EN.
module disparity_sequencer #(
  parameter int unsigned WIDTH     = 250,
  parameter int unsigned HEIGHT    = 125,
  parameter int unsigned TIMEOUT_W = 24,
  parameter int unsigned GAP       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear_err,
  input  logic       left_ready,
  input  logic       right_ready,
  input  logic [7:0] left_data,
  input  logic [7:0] right_data,
  output logic       left_rd,
  output logic       right_rd,
  input  logic       disp_image_sel,
  input  logic       disp_idle,
  input  logic [2:0] disp_state,
  output logic       disp_enable,
  output logic [7:0] image_data,
  output logic       buffer_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       error
);
  localparam logic [15:0]       TOTAL    = 16'(2 * WIDTH * HEIGHT);
  localparam logic [2:0]        ENG_READ = 3'b001;
  localparam int unsigned       GAP_CW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUF,
    S_LAUNCH,
    S_STREAM,
    S_COMPUTE,
    S_DONE,
    S_GAP_WAIT,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       pix_cnt_q, pix_cnt_d;
  logic              reading_q, reading_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              disp_enable_q, disp_enable_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              error_q, error_d;
  logic              buffer_ready_q, buffer_ready_d;
`ifdef DISP_SEQ_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  logic rd;
  logic sel_ready;

  // Pop strobes and pixel mux are combinational so the engine samples pixel k on the edge that pops it.
  always_comb begin
    rd         = (state_q == S_STREAM) && (disp_state == ENG_READ) && (pix_cnt_q < TOTAL);
    left_rd    = rd & ~disp_image_sel;
    right_rd   = rd & disp_image_sel;
    image_data = (state_q == S_STREAM) ? (disp_image_sel ? right_data : left_data) : '0;
    sel_ready  = disp_image_sel ? right_ready : left_ready;
  end

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    reading_d     = reading_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
`ifdef DISP_SEQ_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_WAIT_BUF;
      end
      S_WAIT_BUF: begin
        if (!run) state_d = S_IDLE;
        else if (left_ready && right_ready && disp_idle) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        pix_cnt_d = '0;
        reading_d = 1'b0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (rd) pix_cnt_d = pix_cnt_q + 16'd1;
        if (disp_state == ENG_READ) reading_d = 1'b1;
        // The engine enters READ one cycle after enable, so only a departure after READ was seen ends the stream.
        if (rd && !sel_ready) begin
          state_d = S_ERROR;
        end else if (reading_q && (disp_state != ENG_READ)) begin
          if (pix_cnt_q == TOTAL) begin
            state_d = S_COMPUTE;
`ifdef DISP_SEQ_WATCHDOG_EN
            wd_cnt_d = '0;
`endif
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_COMPUTE: begin
`ifdef DISP_SEQ_WATCHDOG_EN
        wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
`endif
        if (disp_idle) state_d = S_DONE;
`ifdef DISP_SEQ_WATCHDOG_EN
        else if (wd_cnt_d == '1) state_d = S_ERROR;
`endif
      end
      S_DONE: begin
        frame_count_d = frame_count_q + 8'd1;
        gap_cnt_d     = '0;
        state_d       = S_GAP_WAIT;
      end
      S_GAP_WAIT: begin
        if (gap_cnt_q == GAP_LAST) state_d = run ? S_WAIT_BUF : S_IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_CW'(1);
      end
      S_ERROR: begin
        if (clear_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    disp_enable_d  = (state_d == S_LAUNCH);
    busy_d         = (state_d != S_IDLE) && (state_d != S_ERROR);
    frame_done_d   = (state_d == S_DONE);
    error_d        = (state_d == S_ERROR);
    buffer_ready_d = (state_q == S_WAIT_BUF) && left_ready && right_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pix_cnt_q      <= '0;
      reading_q      <= 1'b0;
      gap_cnt_q      <= '0;
      frame_count_q  <= '0;
      disp_enable_q  <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      error_q        <= 1'b0;
      buffer_ready_q <= 1'b0;
`ifdef DISP_SEQ_WATCHDOG_EN
      wd_cnt_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      reading_q      <= reading_d;
      gap_cnt_q      <= gap_cnt_d;
      frame_count_q  <= frame_count_d;
      disp_enable_q  <= disp_enable_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      error_q        <= error_d;
      buffer_ready_q <= buffer_ready_d;
`ifdef DISP_SEQ_WATCHDOG_EN
      wd_cnt_q       <= wd_cnt_d;
`endif
    end
  end

  assign disp_enable  = disp_enable_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign error        = error_q;
  assign buffer_ready = buffer_ready_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_disparity_sequencer.sv
// Self-checking bench for disparity_sequencer: FWFT FIFO models, a behavioural engine and a pixel scoreboard.
module tb_disparity_sequencer;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned GAP   = 4;
  localparam int unsigned TW    = 4;
  localparam int unsigned FRAME = W * H;
  localparam int unsigned TOTAL = 2 * FRAME;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       clear_err = 1'b0;
  logic       left_ready = 1'b0;
  logic       right_ready = 1'b0;
  logic [7:0] left_data, right_data;
  logic       left_rd, right_rd, disp_enable, buffer_ready, busy, frame_done, error;
  logic [7:0] image_data, frame_count;

  logic [2:0]  e_state = 3'b000;
  logic        e_sel = 1'b0;
  logic        e_idle = 1'b1;
  logic        eng_abort = 1'b0;
  int unsigned e_pops = 0, e_cmp = 0;
  int unsigned cfg_leave = TOTAL, cfg_cmp = 4;
  int unsigned l_idx = 0, r_idx = 0;

  disparity_sequencer #(.WIDTH(W), .HEIGHT(H), .TIMEOUT_W(TW), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .run(run), .clear_err(clear_err),
    .left_ready(left_ready), .right_ready(right_ready),
    .left_data(left_data), .right_data(right_data),
    .left_rd(left_rd), .right_rd(right_rd),
    .disp_image_sel(e_sel), .disp_idle(e_idle), .disp_state(e_state),
    .disp_enable(disp_enable), .image_data(image_data), .buffer_ready(buffer_ready),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .error(error)
  );

  always #5 clk = ~clk;

  // FWFT FIFOs: heads follow the pop index and are never flushed by reset.
  always @(posedge clk) begin
    if (left_rd)  l_idx <= l_idx + 1;
    if (right_rd) r_idx <= r_idx + 1;
  end
  assign left_data  = 8'(l_idx * 3 + 17);
  assign right_data = 8'(r_idx * 5 + 128);

  // Engine model: READ one cycle after enable, leaves READ after cfg_leave pops, computes cfg_cmp cycles (0 = forever).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_state <= 3'b000; e_sel <= 1'b0; e_idle <= 1'b1; e_pops <= 0; e_cmp <= 0;
    end else if (eng_abort) begin
      e_state <= 3'b000; e_sel <= 1'b0; e_idle <= 1'b1;
    end else begin
      case (e_state)
        3'b000: if (disp_enable) begin
          e_state <= 3'b001; e_idle <= 1'b0; e_sel <= 1'b0; e_pops <= 0;
        end
        3'b001: if (left_rd || right_rd) begin
          e_pops <= e_pops + 1;
          if (e_pops + 1 == FRAME) e_sel <= 1'b1;
          if (e_pops + 1 == cfg_leave) begin e_state <= 3'b010; e_cmp <= 0; end
        end
        3'b010: begin
          e_cmp <= e_cmp + 1;
          if (cfg_cmp != 0 && e_cmp + 1 >= cfg_cmp) begin e_state <= 3'b000; e_idle <= 1'b1; e_sel <= 1'b0; end
        end
        default: e_state <= 3'b000;
      endcase
    end
  end

  typedef struct packed { logic sel; logic [7:0] px; } pix_t;
  typedef struct {
    int unsigned leave_at; int drop_at; bit drop_right; int unsigned cmp_len;
    bit exp_err; int unsigned exp_pops; int unsigned exp_done;
  } vec_t;

  pix_t        sb[$];
  int unsigned en_cycs[$], done_cycs[$];
  int unsigned exp_l = 0, exp_r = 0, exp_fc = 0;
  int unsigned n_vec = 0, n_err = 0;
  int unsigned cyc = 0, pops_seen = 0, en_seen = 0, done_seen = 0, last_pop_cyc = 0, err_cyc = 0;
  logic        err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_frame(input int unsigned n);
    pix_t p;
    for (int unsigned i = 0; i < n; i++) begin
      if (i < FRAME) begin p.sel = 1'b0; p.px = 8'((exp_l + i) * 3 + 17); end
      else begin p.sel = 1'b1; p.px = 8'((exp_r + i - FRAME) * 5 + 128); end
      sb.push_back(p);
    end
    exp_l += (n < FRAME) ? n : FRAME;
    exp_r += (n > FRAME) ? n - FRAME : 0;
  endtask

  task automatic sample();
    pix_t p;
    if (reset) return;
    if (left_rd || right_rd) begin
      pops_seen++;
      last_pop_cyc = cyc;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_pop: got rd=%b%b data=0x%0h, expected no pop (cycle %0d)", right_rd, left_rd, image_data, cyc);
      end else begin
        p = sb.pop_front();
        chk("pixel", {22'd0, right_rd, left_rd, image_data}, {22'd0, p.sel, ~p.sel, p.px});
      end
    end
    if (disp_enable) begin en_seen++; en_cycs.push_back(cyc); end
    if (frame_done)  begin done_seen++; done_cycs.push_back(cyc); end
    if (error && !err_prev) err_cyc = cyc;
    err_prev = error;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic recover_from_error();
    eng_abort = 1'b1; tick(); eng_abort = 1'b0;
    left_ready = 1'b1; right_ready = 1'b1;
    clear_err = 1'b1; tick(); clear_err = 1'b0; tick();
    chk("clear_err_to_idle", {30'd0, error, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vt[7];
    int unsigned p0, d0, e0;
    bit          dropped, ended;

    vt[0] = '{TOTAL, -1, 1'b0, 4, 1'b0, TOTAL, 1};   // nominal
    vt[1] = '{15,    -1, 1'b0, 4, 1'b1, 15,    0};   // short stream
    vt[2] = '{TOTAL, 10, 1'b1, 4, 1'b1, 11,    0};   // right underflow at pixel 10
    vt[3] = '{TOTAL,  3, 1'b0, 4, 1'b1, 4,     0};   // left underflow at pixel 3
    vt[4] = '{TOTAL, -1, 1'b0, 1, 1'b0, TOTAL, 1};   // one-cycle compute
    vt[5] = '{TOTAL,  8, 1'b1, 4, 1'b1, 9,     0};   // right underflow on its first pixel
    vt[6] = '{TOTAL,  8, 1'b0, 4, 1'b0, TOTAL, 1};   // unselected buffer drop is harmless

    #2 reset = 1'b1;
    tick(); tick();
    chk("reset_outputs",
        {9'd0, disp_enable, left_rd, right_rd, frame_done, busy, buffer_ready, error, frame_count, image_data},
        32'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      p0 = pops_seen; d0 = done_seen; e0 = en_seen;
      cfg_leave = vt[v].leave_at; cfg_cmp = vt[v].cmp_len;
      left_ready = 1'b1; right_ready = 1'b1;
      push_frame(vt[v].exp_pops);
      run = 1'b1;
      dropped = 1'b0; ended = 1'b0;
      for (int c = 0; c < 200 && !ended; c++) begin
        tick();
        if (en_seen != e0) run = 1'b0;
        if (!dropped && vt[v].drop_at >= 0 && e_state == 3'b001 && int'(e_pops) == vt[v].drop_at) begin
          if (vt[v].drop_right) right_ready = 1'b0; else left_ready = 1'b0;
          dropped = 1'b1;
        end
        if (error || done_seen != d0) ended = 1'b1;
      end
      chk($sformatf("v%0d_finished", v), {31'd0, ended}, 32'd1);
      run = 1'b0;
      repeat (GAP + 4) tick();
      chk($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vt[v].exp_err});
      chk($sformatf("v%0d_pops", v), pops_seen - p0, vt[v].exp_pops);
      chk($sformatf("v%0d_done", v), done_seen - d0, vt[v].exp_done);
      chk($sformatf("v%0d_enable", v), en_seen - e0, 1);
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      exp_fc += vt[v].exp_done;
      chk($sformatf("v%0d_frame_count", v), {24'd0, frame_count}, exp_fc & 32'hff);
      chk($sformatf("v%0d_scoreboard_empty", v), sb.size(), 0);
      sb.delete();
      if (vt[v].exp_err) recover_from_error();
      else begin eng_abort = 1'b1; tick(); eng_abort = 1'b0; end
    end

    // Back-to-back frames with run held, including the launch latency from WAIT_BUF.
    cfg_leave = TOTAL; cfg_cmp = 3;
    left_ready = 1'b0; right_ready = 1'b0;
    repeat (3) push_frame(TOTAL);
    d0 = done_seen; en_cycs.delete(); done_cycs.delete();
    run = 1'b1;
    repeat (3) tick();
    chk("wait_buf_hold", {29'd0, busy, buffer_ready, disp_enable}, 32'b100);
    left_ready = 1'b1; right_ready = 1'b1;
    tick();
    chk("launch_latency", {30'd0, disp_enable, buffer_ready}, 32'b11);
    for (int c = 0; c < 600 && (done_seen - d0) < 3; c++) tick();
    run = 1'b0;
    repeat (GAP + 4) tick();
    chk("b2b_done_count", done_seen - d0, 3);
    chk("b2b_enable_count", en_cycs.size(), 3);
    for (int k = 0; k < 2; k++)
      if (en_cycs.size() > k + 1 && done_cycs.size() > k)
        chk($sformatf("b2b_spacing%0d", k), en_cycs[k+1] - done_cycs[k], GAP + 2);
    exp_fc += 3;
    chk("b2b_frame_count", {24'd0, frame_count}, exp_fc & 32'hff);
    chk("b2b_scoreboard_empty", sb.size(), 0);
    sb.delete();

    // Engine never returns to idle during compute.
    cfg_leave = TOTAL; cfg_cmp = 0;
    push_frame(TOTAL);
    p0 = pops_seen; e0 = en_seen;
    run = 1'b1;
    for (int c = 0; c < 100 && (pops_seen - p0) < TOTAL; c++) begin
      tick();
      if (en_seen != e0) run = 1'b0;
    end
    run = 1'b0;
`ifdef DISP_SEQ_WATCHDOG_EN
    for (int c = 0; c < 60 && !error; c++) tick();
    tick();
    chk("wd_error", {31'd0, error}, 32'd1);
    chk("wd_latency", err_cyc - last_pop_cyc, 17);
    recover_from_error();
`else
    repeat (100) tick();
    chk("no_wd_still_computing", {30'd0, error, busy}, 32'b01);
    d0 = done_seen;
    eng_abort = 1'b1; tick(); eng_abort = 1'b0;
    for (int c = 0; c < 20 && done_seen == d0; c++) tick();
    chk("no_wd_done", done_seen - d0, 1);
    exp_fc += 1;
    repeat (GAP + 2) tick();
    chk("no_wd_frame_count", {24'd0, frame_count}, exp_fc & 32'hff);
`endif
    chk("stall_scoreboard_empty", sb.size(), 0);
    sb.delete();

    // Asynchronous reset at pixel 5, then a clean restart.
    cfg_leave = TOTAL; cfg_cmp = 3;
    push_frame(5);
    e0 = en_seen;
    run = 1'b1;
    for (int c = 0; c < 50 && !(e_state == 3'b001 && e_pops == 5); c++) begin
      tick();
      if (en_seen != e0) run = 1'b0;
    end
    run = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {9'd0, disp_enable, left_rd, right_rd, frame_done, busy, buffer_ready, error, frame_count, image_data},
        32'd0);
    chk("reset_scoreboard_empty", sb.size(), 0);
    sb.delete();
    tick(); tick();
    reset = 1'b0;
    exp_fc = 0;
    tick();
    push_frame(TOTAL);
    p0 = pops_seen; d0 = done_seen; e0 = en_seen;
    run = 1'b1;
    for (int c = 0; c < 100 && done_seen == d0; c++) begin
      tick();
      if (en_seen != e0) run = 1'b0;
    end
    run = 1'b0;
    repeat (GAP + 4) tick();
    chk("restart_pops", pops_seen - p0, TOTAL);
    chk("restart_frame_count", {24'd0, frame_count}, 32'd1);
    chk("restart_error", {31'd0, error}, 32'd0);
    chk("restart_scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disparity_sequencer.md
# disparity_sequencer

Frame-level controller for the disparity engine. It waits until both camera frame buffers hold a complete frame, then launches one disparity calculation. During the engine's READ phase it streams the left frame, then the right frame, into the engine's single `image_data` port. It then supervises the compute phase until the engine returns to idle, and signals frame completion. The block sits between the two camera FIFOs (first-word-fall-through) and the disparity engine's `enable`/`image_data`/`image_sel`/`idle`/`state_LED` ports.

## Interface
- `WIDTH`, 250: frame width in pixels (1-indexed count).
- `HEIGHT`, 125: frame height in pixels.
- `TIMEOUT_W`, 24: watchdog counter width.
- `GAP`, 4: idle cycles enforced between frames (minimum 1).

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `run`  in  1  level; while high, frames are processed back-to-back.
- `clear_err`  in  1  one-cycle pulse; leaves ERROR.
- `left_ready`, `right_ready`  in  1  buffer holds at least one full frame.
- `left_data`, `right_data`  in  8  FWFT FIFO heads.
- `left_rd`, `right_rd`  out  1  FIFO pop strobes.
- `disp_image_sel`  in  1  engine's `image_sel`.
- `disp_idle`  in  1  engine's `idle`.
- `disp_state`  in  3  engine's `state_LED` (READ = 3'b001).
- `disp_enable`  out  1  launch pulse to the engine.
- `image_data`  out  8  pixel to the engine.
- `buffer_ready`  out  1  both buffers ready and the sequencer is armed.
- `busy`  out  1  high in every state except IDLE and ERROR.
- `frame_done`  out  1  one-cycle completion pulse.
- `frame_count`  out  8  completed frames.
- `error`  out  1  sticky fault flag.

## Operation
- States: IDLE, WAIT_BUF, LAUNCH, STREAM, COMPUTE, DONE, GAP_WAIT, ERROR.
- **IDLE**
  - `run` = 1 → WAIT_BUF.
- **WAIT_BUF**
  - `buffer_ready` = `left_ready & right_ready`.
  - Both high and `disp_idle` = 1 → LAUNCH.
  - `run` = 0 → IDLE.
- **LAUNCH**
  - `disp_enable` = 1 for exactly this one cycle.
  - Clear `pix_cnt`; → STREAM.
- **STREAM**
  - `image_data` = `disp_image_sel ? right_data : left_data` (combinational mux).
  - Define `rd` = (`disp_state` == 3'b001) & (`pix_cnt` < 2·`WIDTH`·`HEIGHT`).
  - `left_rd` = `rd & ~disp_image_sel`; `right_rd` = `rd & disp_image_sel`.
  - `pix_cnt` (16 bits) increments on every `rd`.
  - `disp_state` leaves READ with `pix_cnt` == 2·W·H → COMPUTE.
  - `disp_state` leaves READ with any other count → ERROR.
  - Selected buffer's ready drops while `rd` → ERROR (underflow).
- **COMPUTE**
  - Watchdog `wd_cnt` increments every cycle.
  - `disp_idle` = 1 → DONE.
- **DONE**
  - `frame_done` = 1 for one cycle.
  - `frame_count` += 1; wraps 255 → 0.
  - → GAP_WAIT.
- **GAP_WAIT**
  - Count `GAP` cycles.
  - Then → WAIT_BUF if `run`, else IDLE.
- **ERROR**
  - `error` = 1; all strobes low.
  - `clear_err` → IDLE.
  - `clear_err` is ignored in other states.
- `run` falling mid-frame does not abort; the frame completes, then the FSM goes to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `disp_enable`, `left_rd`, `right_rd`, `frame_done`, `busy`, `buffer_ready`, `error` = 0.
  - `frame_count` = 0; `image_data` = 0.
  - `pix_cnt` = 0; `wd_cnt` = 0.
- Asynchronous reset mid-frame forces IDLE immediately. FIFO contents are not flushed.
- `disp_enable`, `frame_done`, `busy`, `error` and `buffer_ready` are registered outputs.
- `rd` strobes and `image_data` are combinational from registered state and engine inputs. The engine samples pixel k on the same edge that pops it.
- Launch latency: LAUNCH is entered 1 cycle after both ready signals are seen high in WAIT_BUF. The engine enters READ 1 cycle after `disp_enable`.
- Stream length: exactly 2·W·H pops (62 500 for the defaults), one per clock, with no bubbles.
- DONE follows `disp_idle` rising by 1 cycle.
- Minimum inter-launch spacing: DONE + `GAP` + 1 cycles.
- If `clear_err` and `reset` are asserted together, reset wins.

## Configuration
- Macro: `DISP_SEQ_WATCHDOG_EN`.
- Defined:
  - `wd_cnt` is cleared on COMPUTE entry.
  - `wd_cnt` reaching all-ones before `disp_idle` → ERROR.
- Undefined:
  - No `wd_cnt` register.
  - COMPUTE waits indefinitely.
  - ERROR is reachable only from STREAM faults.

## Test plan
- Nominal frame, W=4 H=2:
  - Stimulus: both ready, `run` = 1, engine model.
  - Required: one `disp_enable` pulse; 8 `left_rd` then 8 `right_rd`; `image_data` matches the FIFO heads.
  - Required: `frame_done` pulse; `frame_count` = 1; `error` = 0.
- Back-to-back: `run` held for 3 frames → 3 `frame_done` pulses, each separated by ≥`GAP`+1 cycles; `frame_count` = 3.
- Short stream: engine leaves READ after 15 pops (W=4 H=2) → ERROR, `error` = 1; `clear_err` → IDLE with `error` = 0.
- Underflow: drop `right_ready` at pixel 10 → ERROR; no further strobes.
- Watchdog, macro defined, `TIMEOUT_W` = 4: hold `disp_idle` low → ERROR 15 cycles after COMPUTE entry. Without the macro, no error after 100 cycles.
- Reset at pixel 5 → all outputs at reset values in the same cycle. A new `run` restarts cleanly with `frame_count` = 0.
